lbp_host_mem: RTL
=================

# lbp_host_mem

Memory-side responder for the LBP engine's gray-image and result interfaces. It loads a 128×128 8-bit gray image from a streaming loader port and serves pixel reads to the engine over the gray_addr/gray_req/gray_ready/gray_data handshake. It also captures the engine's lbp_addr/lbp_valid/lbp_data result writes into a result array, and exposes that array on a read-back port once the engine raises finish. It sits between the image source/checker and the LBP engine, as the other end of both of the engine's memory interfaces.

## Interface
- IMG_W, 128, image width and height in pixels (square image)
- ADDR_W, 14, address width; must satisfy 2^ADDR_W = IMG_W*IMG_W
- DATA_W, 8, pixel and LBP code width

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset, asynchronous, active-high
- img_valid  in  1  loader pixel valid
- img_data  in  DATA_W  loader pixel, raster order starting at address 0
- img_ready  out  1  loader may transfer; a pixel moves when img_valid && img_ready
- gray_addr  in  ADDR_W  engine pixel read address
- gray_req  in  1  engine read request
- gray_ready  out  1  image served; the engine samples gray_data on every edge where this is high
- gray_data  out  DATA_W  pixel at gray_addr
- lbp_addr  in  ADDR_W  engine result write address
- lbp_valid  in  1  engine result write strobe
- lbp_data  in  DATA_W  engine result code
- finish  in  1  engine completion
- rd_addr  in  ADDR_W  result read-back address
- rd_data  out  DATA_W  result read-back data, registered
- done  out  1  finish captured; result array frozen
- wr_count  out  ADDR_W+1  number of accepted result writes
- err_border  out  1  sticky flag: a result write targeted a border address

## Operation
- Storage: img array and res array, each IMG_W*IMG_W × DATA_W.
- Border address: column 0, column IMG_W-1, row 0, or row IMG_W-1.
- FSM states LOAD → SERVE → DONE. No other transitions; DONE is terminal until reset.
- LOAD:
  - img_ready=1, gray_ready=0.
  - Each transfer writes img[load_cnt] and increments load_cnt (ADDR_W+1 bits).
  - The transfer with load_cnt = IMG_W*IMG_W-1 moves the FSM to SERVE on the same edge.
- SERVE:
  - img_ready=0, gray_ready=1 (see Configuration).
  - gray_data = img[gray_addr] when gray_req=1, else 0.
  - An edge with lbp_valid=1 writes res[lbp_addr]=lbp_data and increments wr_count, saturating at all-ones.
  - A repeated lbp_addr overwrites; each write counts.
  - A write to a border address is still stored and sets err_border.
  - finish=1 moves the FSM to DONE. A write on the same edge is accepted.
- DONE:
  - done=1, gray_ready=0, img_ready=0.
  - lbp_valid is ignored; wr_count and err_border hold.
- Read-back:
  - Active in every state.
  - rd_data <= border(rd_addr) ? 0 : res[rd_addr], so border pixels read 0 with no array clear.
- lbp_valid in LOAD is ignored. finish in LOAD is ignored. img_valid outside LOAD is ignored.

## Timing
- Reset values: img_ready=1, gray_ready=0, gray_data=0 (combinational, gray_req low), rd_data=0, done=0, wr_count=0, err_border=0; FSM=LOAD, load_cnt=0.
- Array contents are not reset.
- Reset mid-operation returns to LOAD with load_cnt=0. The previous image must be reloaded.
- gray_data is a combinational read with zero latency. An address registered by the engine at edge k is returned before edge k+1.
- gray_ready rises in the cycle after the edge that accepted the last pixel.
- Result writes take effect at the edge where lbp_valid=1.
- rd_data has 1-cycle latency. A read of an address written on the same edge returns the old value.
- done rises in the cycle after the edge where finish=1 is sampled in SERVE.
- Load throughput: 1 pixel/cycle; a full image takes 16384 cycles minimum.

## Configuration
- LBP_HOST_STALL_EN defined:
  - In SERVE, gray_ready = bit 0 of a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset).
  - The LFSR advances every cycle in SERVE.
  - Stresses the engine's wait behaviour; gray_data remains valid regardless of gray_ready.
- LBP_HOST_STALL_EN undefined: gray_ready is constant 1 throughout SERVE. No LFSR is built.

## Test plan
- Reset, then 16384 pixels img_data=addr[7:0] with img_valid held high -> img_ready falls after the last pixel, gray_ready=1 on the next cycle.
- In SERVE, gray_req=1 and gray_addr=129 -> gray_data=8'h81 in the same cycle; with gray_req=0 -> gray_data=0.
- lbp_valid writes 8'h5A to address 130, then finish=1 -> done=1 one cycle later; rd_addr=130 returns 8'h5A after one cycle, and wr_count=1.
- Write to address 128 (column 0) -> err_border=1, and rd_addr=128 returns 0. Write to address 0 in DONE -> ignored, wr_count unchanged.
- Full run against the LBP engine on a random image -> wr_count=15876, err_border=0, and every interior rd_data matches the golden LBP codes.
- Assert reset at pixel 5000 of a load -> FSM in LOAD, gray_ready=0, wr_count=0; a fresh 16384-pixel load completes normally. With LBP_HOST_STALL_EN, repeat the full run -> identical results.

Source files
------------

// File: rtl/lbp_host_mem.sv
// rtl/lbp_host_mem.sv - image/result memory responder for the LBP engine
// Optional build macro: LBP_HOST_STALL_EN (pseudo-random gray_ready stalls in SERVE)
module lbp_host_mem #(
  parameter int IMG_W  = 128,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              img_valid,
  input  logic [DATA_W-1:0] img_data,
  output logic              img_ready,
  input  logic [ADDR_W-1:0] gray_addr,
  input  logic              gray_req,
  output logic              gray_ready,
  output logic [DATA_W-1:0] gray_data,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic              lbp_valid,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  output logic              err_border
);
  localparam int NPIX  = IMG_W * IMG_W;
  localparam int COL_W = ADDR_W / 2;
  localparam int ROW_W = ADDR_W - COL_W;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_W - 1);
  localparam logic [ADDR_W:0]  PIX_LAST = (ADDR_W + 1)'(NPIX - 1);

  typedef enum logic [1:0] {ST_LOAD, ST_SERVE, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   load_cnt_q, load_cnt_d;
  logic [ADDR_W:0]   wr_count_q, wr_count_d;
  logic              err_border_q, err_border_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              img_ready_q, img_ready_d;
  logic              serve_q, serve_d;
  logic              done_q, done_d;
  logic              img_we, res_we;

  logic [DATA_W-1:0] img_mem [NPIX];
  logic [DATA_W-1:0] res_mem [NPIX];

  function automatic logic is_border(input logic [ADDR_W-1:0] a);
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    col = a[COL_W-1:0];
    row = a[ADDR_W-1:COL_W];
    return (col == '0) || (col == COL_LAST) || (row == '0) || (row == ROW_LAST);
  endfunction

  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    wr_count_d   = wr_count_q;
    err_border_d = err_border_q;
    img_ready_d  = img_ready_q;
    serve_d      = serve_q;
    done_d       = done_q;
    img_we       = 1'b0;
    res_we       = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (img_valid) begin
          img_we     = 1'b1;
          load_cnt_d = load_cnt_q + 1'b1;
          if (load_cnt_q == PIX_LAST) begin
            state_d     = ST_SERVE;
            img_ready_d = 1'b0;
            serve_d     = 1'b1;
          end
        end
      end
      ST_SERVE: begin
        if (lbp_valid) begin
          res_we = 1'b1;
          if (wr_count_q != '1) wr_count_d = wr_count_q + 1'b1;
          if (is_border(lbp_addr)) err_border_d = 1'b1;
        end
        if (finish) begin
          state_d = ST_DONE;
          serve_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
    // Border results are masked on read so the array never needs clearing.
    rd_data_d = is_border(rd_addr) ? '0 : res_mem[rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_LOAD;
      load_cnt_q   <= '0;
      wr_count_q   <= '0;
      err_border_q <= 1'b0;
      rd_data_q    <= '0;
      img_ready_q  <= 1'b1;
      serve_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      wr_count_q   <= wr_count_d;
      err_border_q <= err_border_d;
      rd_data_q    <= rd_data_d;
      img_ready_q  <= img_ready_d;
      serve_q      <= serve_d;
      done_q       <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (img_we) img_mem[load_cnt_q[ADDR_W-1:0]] <= img_data;
    if (res_we) res_mem[lbp_addr] <= lbp_data;
  end

`ifdef LBP_HOST_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == ST_SERVE)
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  assign gray_ready = serve_q & lfsr_q[0];
`else
  assign gray_ready = serve_q;
`endif

  assign gray_data  = gray_req ? img_mem[gray_addr] : '0;
  assign img_ready  = img_ready_q;
  assign rd_data    = rd_data_q;
  assign done       = done_q;
  assign wr_count   = wr_count_q;
  assign err_border = err_border_q;
endmodule
